// File: rtl/bf_loop_scanner_if.sv
// Controller <-> bracket-scanner bundle: scan request, instruction-memory port
// and completion status.
interface bf_loop_scanner_if #(
  parameter int PC_WIDTH = 8,
  parameter int OP_WIDTH = 8
);
  logic                start;
  logic                dir;
  logic [PC_WIDTH-1:0] pc_in;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [OP_WIDTH-1:0] imem_data;
  logic                busy;
  logic                done;
  logic                error;
  logic [PC_WIDTH-1:0] pc_out;

  modport master (
    output start, dir, pc_in, imem_data,
    input  imem_addr, busy, done, error, pc_out
  );

  modport slave (
    input  start, dir, pc_in, imem_data,
    output imem_addr, busy, done, error, pc_out
  );
endinterface

// File: rtl/bf_loop_scanner.sv
// Bracket-matching scanner: walks instruction memory one address per cycle from
// a loop bracket, tracking nesting depth, and reports the matching bracket PC.
module bf_loop_scanner #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  OP_WIDTH    = 8,
  parameter int                  DEPTH_WIDTH = 8,
  parameter logic [OP_WIDTH-1:0] OPEN_CODE   = 8'h5B,
  parameter logic [OP_WIDTH-1:0] CLOSE_CODE  = 8'h5D
) (
  input  logic               clk,
  input  logic               reset,
  bf_loop_scanner_if.slave   bus
);

  localparam logic [PC_WIDTH-1:0]    PC_MAX    = '1;
  localparam logic [PC_WIDTH-1:0]    PC_ONE    = PC_WIDTH'(1);
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                 r_state;
  logic                   r_dir;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    r_pc_out;
  logic [DEPTH_WIDTH-1:0] r_depth;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  logic w_opener;
  logic w_closer;
  logic w_at_edge;
  logic w_start_edge;

  // Going backward, ']' opens a nesting level and '[' closes one.
  assign w_opener     = r_dir ? (bus.imem_data == CLOSE_CODE) : (bus.imem_data == OPEN_CODE);
  assign w_closer     = r_dir ? (bus.imem_data == OPEN_CODE)  : (bus.imem_data == CLOSE_CODE);
  assign w_at_edge    = r_dir ? (r_pc == '0) : (r_pc == PC_MAX);
  assign w_start_edge = bus.dir ? (bus.pc_in == '0) : (bus.pc_in == PC_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dir    <= 1'b0;
      r_pc     <= '0;
      r_pc_out <= '0;
      r_depth  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_dir  <= bus.dir;
            r_busy <= 1'b1;
            if (w_start_edge) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_pc    <= bus.dir ? (bus.pc_in - PC_ONE) : (bus.pc_in + PC_ONE);
              r_depth <= DEPTH_ONE;
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (w_closer && r_depth == DEPTH_ONE) begin
            r_pc_out <= r_pc;
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_opener && r_depth == DEPTH_MAX) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (w_opener)      r_depth <= r_depth + DEPTH_ONE;
            else if (w_closer) r_depth <= r_depth - DEPTH_ONE;
            // Out of addresses with the bracket still open: unmatched.
            if (w_at_edge) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_pc <= r_dir ? (r_pc - PC_ONE) : (r_pc + PC_ONE);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_err;
  assign bus.pc_out    = r_pc_out;

endmodule

// File: tb/tb_bf_loop_scanner.sv
// Scoreboard bench for bf_loop_scanner: directed bracket cases plus randomized
// memory images checked against a behavioural bracket-matching model.
module tb_bf_loop_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bf_loop_scanner_if #(.PC_WIDTH(8), .OP_WIDTH(8)) b0 ();
  bf_loop_scanner_if #(.PC_WIDTH(8), .OP_WIDTH(8)) b1 ();

  logic [7:0] mem [256];
  assign b0.imem_data = mem[b0.imem_addr];
  assign b1.imem_data = mem[b1.imem_addr];

  bf_loop_scanner u_dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  bf_loop_scanner #(.DEPTH_WIDTH(2)) u_dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  typedef struct { int err; int pc; int cyc; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  int   last_pc [2];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nchk = nchk + 1;
    if (act != exp) begin
      nfail = nfail + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int u, input int err, input int pc);
    exp_t e;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      nchk = nchk + 1;
      nfail = nfail + 1;
      $display("FAIL unexpected_done: dut%0d done with nothing outstanding (cycle %0d)", u, cyc);
    end else begin
      e = (u == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("dut%0d_error", u), err, e.err);
      chk($sformatf("dut%0d_pc_out", u), pc, e.pc);
      chk($sformatf("dut%0d_done_cycle", u), cyc, e.cyc);
    end
  endtask

  always @(negedge clk) if (!reset && b0.done) mon(0, int'(b0.error), int'(b0.pc_out));
  always @(negedge clk) if (!reset && b1.done) mon(1, int'(b1.error), int'(b1.pc_out));

  // Reference: step through addresses counting open brackets; an address
  // outside 0..255 or a depth above 2^dw-1 means no match.
  function automatic void model(input int dw, input bit d, input int p,
                                output bit err, output int mpc, output int lat);
    int depth = 1;
    int a = p;
    int st = d ? -1 : 1;
    int maxd = (1 << dw) - 1;
    err = 1'b1;
    mpc = 0;
    lat = 1;
    if (p + st < 0 || p + st > 255) return;
    for (int k = 1; k <= 256; k++) begin
      a = a + st;
      lat = k + 1;
      if (mem[a] == (d ? 8'h5B : 8'h5D)) begin
        if (depth == 1) begin err = 1'b0; mpc = a; return; end
        depth = depth - 1;
      end else if (mem[a] == (d ? 8'h5D : 8'h5B)) begin
        if (depth == maxd) return;
        depth = depth + 1;
      end
      if (a + st < 0 || a + st > 255) return;
    end
  endfunction

  task automatic drive(input int u, input bit s, input bit d, input int p);
    if (u == 0) begin b0.start = s; b0.dir = d; b0.pc_in = 8'(p); end
    else        begin b1.start = s; b1.dir = d; b1.pc_in = 8'(p); end
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the scan.
  task automatic scan_exp(input int u, input bit d, input int p,
                          input int err, input int pc, input int lat, input bit extra);
    exp_t e;
    bit   seen = 1'b0;
    e.err = err;
    e.pc  = err ? last_pc[u] : pc;
    e.cyc = cyc + lat;
    if (!err) last_pc[u] = pc;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    drive(u, 1'b1, d, p);
    @(posedge clk); #1;
    drive(u, 1'b0, d, p);
    if (extra) begin
      @(posedge clk); #1;
      drive(u, 1'b1, ~d, $urandom_range(255));
      @(posedge clk); #1;
      drive(u, 1'b0, d, p);
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ((u == 0 && b0.done) || (u == 1 && b1.done)) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      nchk = nchk + 1;
      nfail = nfail + 1;
      $display("FAIL done_timeout: dut%0d no done within 600 cycles", u);
    end
    @(posedge clk); #1;
    chk($sformatf("dut%0d_busy_after_done", u), (u == 0) ? int'(b0.busy) : int'(b1.busy), 0);
  endtask

  task automatic scan_rand(input int u, input int dw);
    bit d;
    int p;
    bit err;
    int mpc;
    int lat;
    d = 1'($urandom_range(1));
    p = $urandom_range(255);
    model(dw, d, p, err, mpc, lat);
    scan_exp(u, d, p, int'(err), mpc, lat, 1'b0);
  endtask

  initial begin
    int r;
    drive(0, 1'b0, 1'b0, 0);
    drive(1, 1'b0, 1'b0, 0);
    last_pc[0] = 0;
    last_pc[1] = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h5B; mem[1] = 8'h2B; mem[2] = 8'h5B;
    mem[3] = 8'h2D; mem[4] = 8'h5D; mem[5] = 8'h5D;
    for (int i = 10; i <= 13; i++) mem[i] = 8'h5B;
    mem[250] = 8'h5B;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_done", int'(b0.done), 0);
    chk("rst_error", int'(b0.error), 0);
    chk("rst_pc_out", int'(b0.pc_out), 0);
    chk("rst_imem_addr", int'(b0.imem_addr), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    scan_exp(0, 1'b0, 0, 0, 5, 6, 1'b0);
    scan_exp(0, 1'b1, 5, 0, 0, 6, 1'b0);
    scan_exp(0, 1'b0, 2, 0, 4, 3, 1'b0);
    scan_exp(0, 1'b1, 4, 0, 2, 3, 1'b0);
    scan_exp(0, 1'b0, 250, 1, 0, 6, 1'b0);
    scan_exp(0, 1'b0, 255, 1, 0, 1, 1'b0);
    scan_exp(0, 1'b1, 0, 1, 0, 1, 1'b0);
    scan_exp(0, 1'b0, 0, 0, 5, 6, 1'b1);
    scan_exp(1, 1'b0, 10, 1, 0, 4, 1'b0);
    scan_exp(1, 1'b0, 2, 0, 4, 3, 1'b0);

    // Reset in cycle 3 of the outer forward scan: no done may follow.
    drive(0, 1'b1, 1'b0, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    chk("scan_busy", int'(b0.busy), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_pc[0] = 0;
    last_pc[1] = 0;
    chk("abort_busy", int'(b0.busy), 0);
    chk("abort_done", int'(b0.done), 0);
    chk("abort_error", int'(b0.error), 0);
    chk("abort_pc_out", int'(b0.pc_out), 0);
    chk("abort_imem_addr", int'(b0.imem_addr), 0);
    repeat (10) @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(99);
        mem[i] = (r < 25) ? 8'h5B : (r < 50) ? 8'h5D : 8'($urandom_range(255));
      end
      scan_rand(0, 8);
      scan_rand(1, 2);
    end

    repeat (5) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/bf_loop_scanner.md
# bf_loop_scanner

Parametrised bracket-matching engine for the BF machine's program counter path. On a `[` whose cell is zero, or a `]` whose cell is non-zero, the controller hands the scanner the current PC and direction. The scanner walks instruction memory one address per cycle, tracking nesting depth, and returns the PC of the matching bracket. It is the sequential successor to the single-step PC incrementer/decrementer and replaces the controller's ad-hoc loop-skip states.

## Interface
Parameters:
- `PC_WIDTH`, 8: program counter / instruction address width.
- `OP_WIDTH`, 8: instruction word width.
- `DEPTH_WIDTH`, 8: nesting-depth counter width.
- `OPEN_CODE`, 8'h5B: encoding of `[`.
- `CLOSE_CODE`, 8'h5D: encoding of `]`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request scan; sampled only in IDLE.
- `dir`  in  1  0 = forward from `[`; 1 = backward from `]`. Latched with `start`.
- `pc_in`  in  PC_WIDTH  address of the bracket that starts the scan. Latched with `start`.
- `imem_addr`  out  PC_WIDTH  instruction memory address (registered).
- `imem_data`  in  OP_WIDTH  instruction at `imem_addr`. Asynchronous read, valid in the same cycle.
- `busy`  out  1  high in SCAN and DONE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  valid with `done`; 1 = no match found.
- `pc_out`  out  PC_WIDTH  matched bracket address. Updated only on a successful match; held otherwise.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE + `start`:
  - `dir`=0 and `pc_in`=2^PC_WIDTH-1, or `dir`=1 and `pc_in`=0: no next address exists. Go to DONE with error flag set.
  - Otherwise: `pc` <= `pc_in`+1 (dir 0) or `pc_in`-1 (dir 1); `depth` <= 1; go to SCAN.
- SCAN examines `imem_data` at `imem_addr`=`pc` once per cycle.
- Forward scan:
  - OPEN_CODE: `depth`+1.
  - CLOSE_CODE: `depth`-1.
- Backward scan: the roles of OPEN_CODE and CLOSE_CODE are swapped.
- All other opcodes leave `depth` unchanged.
- Match: the decrement takes `depth` from 1 to 0. Then `pc_out` <= `pc`, error flag <= 0, go to DONE.
- No match in the cycle:
  - Next step would cross the address boundary (forward at all-ones, backward at 0): error, go to DONE.
  - Otherwise `pc` steps by ±1.
- Depth overflow: an increment while `depth`=2^DEPTH_WIDTH-1 sets error and goes to DONE. There is no wrap.
- DONE: `done`=1 for exactly one cycle, `error` = flag, then IDLE.
- `start` is ignored while `busy`=1.
- `pc_out` is unchanged on an error completion.
- All arithmetic is modulo-free: boundaries are detected explicitly, never wrapped.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `error`=0, `pc_out`=0, `imem_addr`=0; `depth`=0.
- Reset asserted mid-scan aborts immediately; no `done` is produced.
- Latency: `start` sampled in cycle 0; match at distance k from `pc_in` gives `done` in cycle k+1.
- Boundary-start errors give `done`+`error` in cycle 1.
- `imem_addr` equals `pc` during SCAN and holds its last value in IDLE/DONE.
- `busy` rises in cycle 1 after an accepted `start` and falls in the cycle after `done`.
- A new `start` is accepted at the earliest in the cycle after DONE.
- `pc_out` and `error` are stable from the `done` cycle until the next completion.

## Test plan
Memory image: 0 `[`, 1 `+`, 2 `[`, 3 `-`, 4 `]`, 5 `]`; all other addresses 8'h00.
- Forward outer: `start`, `dir`=0, `pc_in`=0 -> `done` in cycle 6, `pc_out`=5, `error`=0.
- Backward outer: `dir`=1, `pc_in`=5 -> `done` in cycle 6, `pc_out`=0, `error`=0. Inner scans: `dir`=0, `pc_in`=2 -> `pc_out`=4 in cycle 3; `dir`=1, `pc_in`=4 -> `pc_out`=2.
- Unmatched: `[` at 250, nothing after; `dir`=0, `pc_in`=250 -> `done`+`error`=1 in cycle 6 (after 255 is examined); `pc_out` holds its previous value. Separately, `pc_in`=255, `dir`=0 -> `done`+`error` in cycle 1.
- Depth overflow with `DEPTH_WIDTH`=2: addresses 10..13 all `[`; `dir`=0, `pc_in`=10 -> `error`=1 with `done` in cycle 4.
- Protocol: `start` pulsed again during SCAN -> ignored, single `done`. Reset asserted in cycle 3 of the outer scan -> no `done`, all outputs at reset values next cycle, `busy`=0.
